// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and constants for the PWM capture / generation
//               blocks: FSM state encoding, clock/tick rates, servo period
//               and the default loss-of-signal timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int CLK_HZ                = 48_000_000;
    localparam int TICK_HZ               = 24_000_000;
    localparam int SERVO_PERIOD_TICKS    = 480_000;   // 20 ms at TICK_HZ
    localparam int TIMEOUT_TICKS_DEFAULT = 960_000;   // 40 ms at TICK_HZ

    localparam int CNT_W_DEFAULT   = 20;
    localparam int WIDTH_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef logic [CNT_W_DEFAULT-1:0]   cnt_t;
    typedef logic [WIDTH_W_DEFAULT-1:0] width_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Two-flop synchronizer for an asynchronous pin followed by an
//               edge register. Produces the synchronized level and one-CLK
//               rise / fall pulses.
// Ports       : CLK  - system clock
//               RST  - asynchronous active-high reset (all flops to 0)
//               din  - asynchronous input pin
//               level- synchronized pin level
//               rise - one-CLK pulse on a 0->1 transition of level
//               fall - one-CLK pulse on a 1->0 transition of level
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Pulse-width decoder. Measures high time and rising-to-rising
//               period of one PWM/servo input in prescaled ticks and
//               publishes each completed measurement with a one-CLK strobe.
//               Declares loss of signal when no valid edge arrives within
//               TIMEOUT_TICKS.
// Ports       : CLK         - system clock (48 MHz)
//               RST         - asynchronous active-high reset
//               pwm_in      - asynchronous PWM input pin
//               width_out   - last high time in ticks (saturating)
//               period_out  - last rising-to-rising period in ticks
//               meas_valid  - one-CLK strobe when width/period update
//               width_sat   - last width was clamped to 2^WIDTH_W-1
//               signal_lost - level, no valid edge within TIMEOUT_TICKS
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CLK_DIV       = CLK_HZ / TICK_HZ,
    parameter int CNT_W         = CNT_W_DEFAULT,
    parameter int WIDTH_W       = WIDTH_W_DEFAULT,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               pwm_in,
    output logic [WIDTH_W-1:0] width_out,
    output logic [CNT_W-1:0]   period_out,
    output logic               meas_valid,
    output logic               width_sat,
    output logic               signal_lost
);

    localparam int                 c_div_w     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_timeout   = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0]   c_width_max = CNT_W'((2 ** WIDTH_W) - 1);

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic w_level;
    logic w_rise;
    logic w_fall;

    sync_edge_det u_sync (
        .CLK   (CLK),
        .RST   (RST),
        .din   (pwm_in),
        .level (w_level),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // ------------------------------------------------------------------
    // Arming after reset. The synchronizer restarts from 0, so a pin that
    // is already high when RST drops shows up as a rise in the middle of
    // a pulse. Only once the pipeline has refilled and the pin has been
    // seen low is a rise trusted to start a measurement.
    // ------------------------------------------------------------------
    logic [1:0] r_settle;
    logic       r_armed;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else if (r_settle != 2'd3) begin
            r_settle <= r_settle + 2'd1;
        end else if (!w_level) begin
            r_armed  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Tick prescaler: tick is the wrap cycle of a free-running divider
    // ------------------------------------------------------------------
    logic [c_div_w-1:0] r_div;
    logic               w_tick;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div <= '0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_div_w'(1);
        end
    end

    assign w_tick = (r_div == c_div_last);

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic             w_timeout;
    logic             w_restart;
    logic             w_hi_load;
    logic             w_publish;

    assign w_timeout = (r_state != IDLE) && (r_cnt >= c_timeout);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; timeout outranks any edge seen in the same CLK
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_rise && r_armed) w_state_next = HIGH;
            HIGH: begin
                if (w_timeout)   w_state_next = IDLE;
                else if (w_fall) w_state_next = LOW;
            end
            LOW: begin
                if (w_timeout)   w_state_next = IDLE;
                else if (w_rise) w_state_next = HIGH;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Control outputs of the FSM
    always_comb begin
        w_restart = 1'b0;
        w_hi_load = 1'b0;
        w_publish = 1'b0;
        case (r_state)
            IDLE: w_restart = w_rise && r_armed;
            HIGH: begin
                // A second rise without a fall restarts timing from here
                w_restart = w_rise && !w_timeout;
                w_hi_load = w_fall && !w_timeout;
            end
            LOW: begin
                w_restart = w_rise && !w_timeout;
                w_publish = w_rise && !w_timeout;
            end
            default: ;
        endcase
    end

    // Tick counter: an edge clearing it wins over a coincident tick
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_restart || w_timeout || (r_state == IDLE)) begin
            r_cnt <= '0;
        end else if (w_tick && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hi_cnt <= '0;
        end else if (w_hi_load) begin
            r_hi_cnt <= r_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Published results; held between strobes
    // ------------------------------------------------------------------
    logic [WIDTH_W-1:0] r_width;
    logic [CNT_W-1:0]   r_period;
    logic               r_valid;
    logic               r_sat;
    logic               r_lost;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_width  <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_sat    <= 1'b0;
            r_lost   <= 1'b1;
        end else begin
            r_valid <= w_publish;
            if (w_publish) begin
                r_period <= r_cnt;
                r_lost   <= 1'b0;
                if (r_hi_cnt > c_width_max) begin
                    r_width <= '1;
                    r_sat   <= 1'b1;
                end else begin
                    r_width <= r_hi_cnt[WIDTH_W-1:0];
                    r_sat   <= 1'b0;
                end
            end else if (w_timeout) begin
                r_width  <= '0;
                r_period <= '0;
                r_sat    <= 1'b0;
                r_lost   <= 1'b1;
            end
        end
    end

    assign width_out   = r_width;
    assign period_out  = r_period;
    assign meas_valid  = r_valid;
    assign width_sat   = r_sat;
    assign signal_lost = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture, run with scaled-down
//               widths/timeout so that whole scenarios stay short. Expected
//               measurements come from the pulse durations driven on the pin.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int DIV  = 2;
    localparam int CW   = 20;
    localparam int WW   = 8;
    localparam int TO   = 2000;
    localparam int WMAX = (1 << WW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm = 1'b0;
    logic [WW-1:0] width_out;
    logic [CW-1:0] period_out;
    logic          meas_valid;
    logic          width_sat;
    logic          signal_lost;

    pwm_capture #(
        .CLK_DIV       (DIV),
        .CNT_W         (CW),
        .WIDTH_W       (WW),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .pwm_in      (pwm),
        .width_out   (width_out),
        .period_out  (period_out),
        .meas_valid  (meas_valid),
        .width_sat   (width_sat),
        .signal_lost (signal_lost)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int width;
        int period;
        bit sat;
    } meas_t;

    meas_t q[$];      // strobes observed from the DUT
    meas_t exp_q[$];  // measurements implied by the pulses driven

    always @(negedge clk) begin
        if (meas_valid === 1'b1)
            q.push_back('{int'(width_out), int'(period_out), width_sat});
    end

    // Reference model: a pulse of hi CLK high and lo CLK low measures
    // hi/DIV ticks high and (hi+lo)/DIV ticks period, +-1 tick.
    function automatic meas_t model(input int hi, input int lo);
        meas_t m;
        m.sat    = (hi / DIV) > WMAX;
        m.width  = m.sat ? WMAX : hi / DIV;
        m.period = (hi + lo) / DIV;
        return m;
    endfunction

    function automatic bit near(input int a, input int b);
        return (a >= b - 1) && (a <= b + 1);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm = 1'b1;
        wait_clk(hi);
        pwm = 1'b0;
        wait_clk(lo);
        exp_q.push_back(model(hi, lo));
    endtask

    task automatic final_rise();
        pwm = 1'b1;
        wait_clk(8);
    endtask

    task automatic do_reset();
        pwm = 1'b0;
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(6);
        q.delete();
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        pwm = 1'b0;
        rst = 1'b1;
        wait_clk(3);
        n_checks++; if (width_out !== '0) $display("FAIL reset_width got %0d want 0", width_out); else n_pass++;
        n_checks++; if (period_out !== '0) $display("FAIL reset_period got %0d want 0", period_out); else n_pass++;
        n_checks++; if (meas_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", meas_valid); else n_pass++;
        n_checks++; if (width_sat !== 1'b0) $display("FAIL reset_sat got %b want 0", width_sat); else n_pass++;
        n_checks++; if (signal_lost !== 1'b1) $display("FAIL reset_lost got %b want 1", signal_lost); else n_pass++;
        rst = 1'b0;
        wait_clk(30);
        n_checks++;
        if (signal_lost !== 1'b1 || q.size() != 0)
            $display("FAIL idle_quiet got lost=%b strobes=%0d want lost=1 strobes=0", signal_lost, q.size());
        else n_pass++;
    endtask

    task automatic test_first_lock();
        do_reset();
        pulse(300, 900);
        n_checks++;
        if (q.size() != 0 || signal_lost !== 1'b1)
            $display("FAIL first_rise_only got strobes=%0d lost=%b want 0/1", q.size(), signal_lost);
        else n_pass++;
        pulse(300, 900);
        final_rise();
        n_checks++;
        if (q.size() != 2) $display("FAIL first_lock_count got %0d want 2", q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= q.size())
                $display("FAIL first_lock_strobe%0d missing", i);
            else if (!near(q[i].width, exp_q[i].width) || !near(q[i].period, exp_q[i].period) || q[i].sat != exp_q[i].sat)
                $display("FAIL first_lock_strobe%0d got w=%0d p=%0d s=%0d want w=%0d p=%0d s=%0d (+-1)",
                         i, q[i].width, q[i].period, q[i].sat, exp_q[i].width, exp_q[i].period, exp_q[i].sat);
            else n_pass++;
        end
        n_checks++;
        if (signal_lost !== 1'b0) $display("FAIL first_lock_lost got %b want 0", signal_lost); else n_pass++;
    endtask

    task automatic test_width_step();
        do_reset();
        pulse(200, 1000);
        pulse(400, 800);
        pulse(400, 800);
        final_rise();
        n_checks++;
        if (q.size() != 3) $display("FAIL step_count got %0d want 3", q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= q.size())
                $display("FAIL step_strobe%0d missing", i);
            else if (!near(q[i].width, exp_q[i].width) || !near(q[i].period, exp_q[i].period) || q[i].sat != exp_q[i].sat)
                $display("FAIL step_strobe%0d got w=%0d p=%0d s=%0d want w=%0d p=%0d s=%0d (+-1)",
                         i, q[i].width, q[i].period, q[i].sat, exp_q[i].width, exp_q[i].period, exp_q[i].sat);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        pulse(1000, 400);
        pulse(1000, 400);
        final_rise();
        n_checks++;
        if (q.size() != 2) $display("FAIL sat_count got %0d want 2", q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= q.size())
                $display("FAIL sat_strobe%0d missing", i);
            else if (q[i].width != WMAX || q[i].sat != 1'b1 || !near(q[i].period, exp_q[i].period))
                $display("FAIL sat_strobe%0d got w=%0d p=%0d s=%0d want w=%0d p=%0d s=1 (+-1)",
                         i, q[i].width, q[i].period, q[i].sat, WMAX, exp_q[i].period);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int hi;
        int lo;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            hi = 2 * int'($urandom_range(10, 600));
            // keep clear of the clamp threshold where +-1 blurs width_sat
            if (hi / DIV >= WMAX - 4 && hi / DIV <= WMAX + 4) hi += 40;
            lo = 2 * int'($urandom_range(20, 500));
            pulse(hi, lo);
        end
        final_rise();
        n_checks++;
        if (q.size() != exp_q.size()) $display("FAIL rand_count got %0d want %0d", q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= q.size())
                $display("FAIL rand_strobe%0d missing", i);
            else if (!near(q[i].width, exp_q[i].width) || !near(q[i].period, exp_q[i].period) || q[i].sat != exp_q[i].sat)
                $display("FAIL rand_strobe%0d got w=%0d p=%0d s=%0d want w=%0d p=%0d s=%0d (+-1)",
                         i, q[i].width, q[i].period, q[i].sat, exp_q[i].width, exp_q[i].period, exp_q[i].sat);
            else n_pass++;
        end
    endtask

    // Lock, then the last rise is followed by a stuck pin (low or high).
    task automatic test_timeout(input bit hold_high);
        int n;
        int n_strobes;
        do_reset();
        pulse(300, 900);
        pulse(300, 900);
        pwm = 1'b1;
        n = 0;
        n_strobes = 0;
        while (n < 3 * TO * DIV) begin
            @(negedge clk);
            n++;
            if (!hold_high && n == 300) pwm = 1'b0;
            if (n == 20) begin
                n_strobes = q.size();
                n_checks++;
                if (signal_lost !== 1'b0 || n_strobes != 2)
                    $display("FAIL timeout_lock(hi=%0d) got lost=%b strobes=%0d want 0/2", hold_high, signal_lost, n_strobes);
                else n_pass++;
            end
            if (n > 20 && signal_lost === 1'b1) break;
        end
        n_checks++;
        if (n < TO * DIV - 2 || n > TO * DIV + 10)
            $display("FAIL timeout_delay(hi=%0d) got %0d CLK want %0d..%0d", hold_high, n, TO * DIV - 2, TO * DIV + 10);
        else n_pass++;
        n_checks++;
        if (width_out !== '0 || period_out !== '0 || width_sat !== 1'b0)
            $display("FAIL timeout_clear(hi=%0d) got w=%0d p=%0d s=%b want 0/0/0", hold_high, width_out, period_out, width_sat);
        else n_pass++;
        wait_clk(10);
        n_checks++;
        if (q.size() != n_strobes || signal_lost !== 1'b1)
            $display("FAIL timeout_nostrobe(hi=%0d) got strobes=%0d lost=%b want %0d/1", hold_high, q.size(), signal_lost, n_strobes);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(300, 900);
        pulse(300, 900);
        final_rise();
        wait_clk(100);
        #5 rst = 1'b1;
        #1;
        n_checks++;
        if (width_out !== '0 || period_out !== '0 || meas_valid !== 1'b0 || width_sat !== 1'b0 || signal_lost !== 1'b1)
            $display("FAIL midreset_values got w=%0d p=%0d v=%b s=%b l=%b want 0/0/0/0/1",
                     width_out, period_out, meas_valid, width_sat, signal_lost);
        else n_pass++;
        wait_clk(10);
        rst = 1'b0;
        wait_clk(200);
        pwm = 1'b0;
        wait_clk(900);
        q.delete();
        exp_q.delete();
        pulse(400, 800);
        n_checks++;
        if (q.size() != 0) $display("FAIL midreset_partial got %0d strobes want 0", q.size()); else n_pass++;
        pulse(300, 900);
        final_rise();
        n_checks++;
        if (q.size() != 2) $display("FAIL midreset_count got %0d want 2", q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= q.size())
                $display("FAIL midreset_strobe%0d missing", i);
            else if (!near(q[i].width, exp_q[i].width) || !near(q[i].period, exp_q[i].period) || q[i].sat != exp_q[i].sat)
                $display("FAIL midreset_strobe%0d got w=%0d p=%0d s=%0d want w=%0d p=%0d s=%0d (+-1)",
                         i, q[i].width, q[i].period, q[i].sat, exp_q[i].width, exp_q[i].period, exp_q[i].sat);
            else n_pass++;
        end
    endtask

    // One-CLK glitch in a low phase: its own strobe (if any) is discarded;
    // after it the FSM must keep measuring clean pulses correctly.
    task automatic test_glitch();
        do_reset();
        pulse(300, 900);
        pulse(300, 400);
        pwm = 1'b1;
        wait_clk(1);
        pwm = 1'b0;
        wait_clk(500);
        q.delete();
        exp_q.delete();
        pulse(300, 900);
        pulse(400, 800);
        final_rise();
        n_checks++;
        if (q.size() != 3) $display("FAIL glitch_count got %0d want 3", q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i + 1 >= q.size())
                $display("FAIL glitch_strobe%0d missing", i);
            else if (!near(q[i+1].width, exp_q[i].width) || !near(q[i+1].period, exp_q[i].period) || q[i+1].sat != exp_q[i].sat)
                $display("FAIL glitch_strobe%0d got w=%0d p=%0d s=%0d want w=%0d p=%0d s=%0d (+-1)",
                         i, q[i+1].width, q[i+1].period, q[i+1].sat, exp_q[i].width, exp_q[i].period, exp_q[i].sat);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_first_lock();
        test_width_step();
        test_saturation();
        test_random();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_glitch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
